// File: rtl/serial_add_scheduler.sv
// Round-robin scheduler that shares one bit-serial adder between two requesters.
// Optional subtract mode is enabled with the SERIAL_SUB_EN macro.
module serial_add_scheduler #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  output logic             ack0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             ack1,
`ifdef SERIAL_SUB_EN
  input  logic             sub0,
  input  logic             sub1,
  output logic             res_sub,
`endif
  output logic             busy,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_id,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_cout;
  logic [CW-1:0]    r_cnt;
  logic             r_last_gnt;
  logic             r_ack0;
  logic             r_ack1;
  logic             r_res_id;
  logic             r_res_valid;
  logic             r_busy;
  logic             w_req_any;
  logic             w_gnt_id;
  logic             w_sub_sel;
  logic [WIDTH-1:0] w_a_sel;
  logic [WIDTH-1:0] w_b_sel;
  logic             w_s;
  logic             w_c;
  logic             w_last;
`ifdef SERIAL_SUB_EN
  logic             r_res_sub;
`endif

  function automatic logic maj3(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

  // Arbitration, operand selection and the single-bit full adder
  always_comb begin
    w_req_any = req0 | req1;
    if (req0 && req1) begin
      w_gnt_id = ~r_last_gnt;
    end else if (req1) begin
      w_gnt_id = 1'b1;
    end else begin
      w_gnt_id = 1'b0;
    end
`ifdef SERIAL_SUB_EN
    w_sub_sel = w_gnt_id ? sub1 : sub0;
`else
    w_sub_sel = 1'b0;
`endif
    // Subtraction is A + ~B + 1: invert B here, seed carry with 1 on load.
    w_a_sel = w_gnt_id ? a1 : a0;
    w_b_sel = (w_gnt_id ? b1 : b0) ^ {WIDTH{w_sub_sel}};
    w_s     = r_a[0] ^ r_b[0] ^ r_carry;
    w_c     = maj3(r_a[0], r_b[0], r_carry);
    w_last  = (r_cnt == LAST_CNT);
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_req_any) begin
          w_state_nxt = S_SHIFT;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_SHIFT: begin
        if (w_last) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_SHIFT;
        end
      end
      S_DONE: begin
        if (res_ready) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_DONE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register with registered status flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_busy      <= 1'b0;
      r_res_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_busy      <= (w_state_nxt != S_IDLE);
      r_res_valid <= (w_state_nxt == S_DONE);
    end
  end

  // Operand load, serial add datapath and result registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_a        <= '0;
      r_b        <= '0;
      r_sum      <= '0;
      r_carry    <= 1'b0;
      r_cout     <= 1'b0;
      r_cnt      <= '0;
      r_last_gnt <= 1'b1;
      r_ack0     <= 1'b0;
      r_ack1     <= 1'b0;
      r_res_id   <= 1'b0;
`ifdef SERIAL_SUB_EN
      r_res_sub  <= 1'b0;
`endif
    end else begin
      r_ack0 <= 1'b0;
      r_ack1 <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_req_any) begin
            r_a        <= w_a_sel;
            r_b        <= w_b_sel;
            r_carry    <= w_sub_sel;
            r_cnt      <= '0;
            r_last_gnt <= w_gnt_id;
            r_res_id   <= w_gnt_id;
            r_ack0     <= ~w_gnt_id;
            r_ack1     <= w_gnt_id;
`ifdef SERIAL_SUB_EN
            r_res_sub  <= w_sub_sel;
`endif
          end
        end
        S_SHIFT: begin
          r_a     <= {1'b0, r_a[WIDTH-1:1]};
          r_b     <= {1'b0, r_b[WIDTH-1:1]};
          r_sum   <= {w_s, r_sum[WIDTH-1:1]};
          r_carry <= w_c;
          r_cnt   <= r_cnt + CW'(1);
          if (w_last) begin
            r_cout <= w_c;
          end
        end
        S_DONE: begin
          r_cnt <= r_cnt;
        end
        default: begin
          r_cnt <= '0;
        end
      endcase
    end
  end

  assign ack0      = r_ack0;
  assign ack1      = r_ack1;
  assign busy      = r_busy;
  assign res_valid = r_res_valid;
  assign res_id    = r_res_id;
  assign sum       = r_sum;
  assign cout      = r_cout;
`ifdef SERIAL_SUB_EN
  assign res_sub   = r_res_sub;
`endif

endmodule

// File: tb/tb_serial_add_scheduler.sv
// Directed self-checking bench for serial_add_scheduler (WIDTH=8).
// Subtract-mode steps are compiled in when SERIAL_SUB_EN is defined.
module tb_serial_add_scheduler;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0, req1, res_ready;
  logic [W-1:0] a0, b0, a1, b1;
  logic         ack0, ack1, busy, res_valid, res_id, cout;
  logic [W-1:0] sum;
`ifdef SERIAL_SUB_EN
  logic         sub0, sub1, res_sub;
`endif

  int n_err = 0;
  int n_chk = 0;

  serial_add_scheduler #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .a0(a0), .b0(b0), .ack0(ack0),
    .req1(req1), .a1(a1), .b1(b1), .ack1(ack1),
`ifdef SERIAL_SUB_EN
    .sub0(sub0), .sub1(sub1), .res_sub(res_sub),
`endif
    .busy(busy), .res_valid(res_valid), .res_ready(res_ready),
    .res_id(res_id), .sum(sum), .cout(cout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One operation from a lone requester with res_ready high; called at a negedge.
  task automatic op(input string tag, input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                    input logic [W-1:0] exp_sum, input logic exp_cout);
    int n;
    if (id) begin req1 = 1'b1; a1 = a; b1 = b; end
    else    begin req0 = 1'b1; a0 = a; b0 = b; end
    res_ready = 1'b1;
    @(negedge clk);
    chk({tag, ".ack"}, id ? ack1 : ack0, 1'b1);
    chk({tag, ".ack_other"}, id ? ack0 : ack1, 1'b0);
    req0 = 1'b0;
    req1 = 1'b0;
    n = 0;
    while (!res_valid && n < 20) begin
      @(negedge clk);
      n++;
      if (n == 1) chk({tag, ".ack_pulse"}, {ack0, ack1}, 2'b00);
    end
    chk({tag, ".latency"}, n, W);
    chk({tag, ".sum"}, sum, exp_sum);
    chk({tag, ".cout"}, cout, exp_cout);
    chk({tag, ".res_id"}, res_id, id);
    @(negedge clk);
    chk({tag, ".valid_drop"}, res_valid, 1'b0);
    chk({tag, ".sum_hold"}, sum, exp_sum);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int ack_idx[$];
    int ack_id[$];
    int valid_seen;

    rst = 1'b0; req0 = 1'b0; req1 = 1'b0; res_ready = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
`ifdef SERIAL_SUB_EN
    sub0 = 1'b0; sub1 = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk("reset.outs", {ack0, ack1, busy, res_valid, res_id, cout}, 6'b0);
    chk("reset.sum", sum, 8'h00);
    rst = 1'b1;
    @(negedge clk);

    // Basic add and carry/wrap cases
    op("add_5a_3c", 1'b0, 8'h5A, 8'h3C, 8'h96, 1'b0);
    op("wrap_ff_01", 1'b1, 8'hFF, 8'h01, 8'h00, 1'b1);
    op("wrap_80_80", 1'b1, 8'h80, 8'h80, 8'h00, 1'b1);

    // Arbitration from reset with both requesters held
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    req0 = 1'b1; a0 = 8'h01; b0 = 8'h02;
    req1 = 1'b1; a1 = 8'h03; b1 = 8'h04;
    res_ready = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (ack0 && ack1) chk("arb.both_ack", 2'b11, 2'b00);
      if (ack0 || ack1) begin
        ack_idx.push_back(i);
        ack_id.push_back(ack1 ? 1 : 0);
      end
    end
    req0 = 1'b0;
    req1 = 1'b0;
    chk("arb.count", ack_idx.size(), 4);
    for (int k = 0; k < 4; k++) begin
      if (k < ack_idx.size()) begin
        chk($sformatf("arb.id%0d", k), ack_id[k], k % 2);
        chk($sformatf("arb.time%0d", k), ack_idx[k], 1 + (W + 2) * k);
      end
    end
    n = 0;
    while (busy && n < 20) begin @(negedge clk); n++; end
    chk("arb.idle", busy, 1'b0);

    // Backpressure: result held while res_ready is low, new request waits
    res_ready = 1'b0;
    req0 = 1'b1; a0 = 8'h12; b0 = 8'h34;
    @(negedge clk);
    chk("bp.ack", ack0, 1'b1);
    req0 = 1'b0;
    n = 0;
    while (!res_valid && n < 20) begin @(negedge clk); n++; end
    chk("bp.valid", res_valid, 1'b1);
    req0 = 1'b1; a0 = 8'h01; b0 = 8'h02;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp.hold", {res_valid, res_id, ack0, sum}, {1'b1, 1'b0, 1'b0, 8'h46});
    end
    res_ready = 1'b1;
    @(negedge clk);
    chk("bp.handshake", {res_valid, ack0}, 2'b00);
    @(negedge clk);
    chk("bp.late_ack", ack0, 1'b1);
    req0 = 1'b0;
    n = 0;
    while (!res_valid && n < 20) begin @(negedge clk); n++; end
    chk("bp.sum2", sum, 8'h03);
    @(negedge clk);

    // Reset during the 4th SHIFT cycle
    req0 = 1'b1; a0 = 8'h33; b0 = 8'h44;
    @(negedge clk);
    chk("rm.ack", ack0, 1'b1);
    req0 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rm.outs", {ack0, ack1, busy, res_valid, res_id, cout}, 6'b0);
    chk("rm.sum", sum, 8'h00);
    @(negedge clk);
    rst = 1'b1;
    valid_seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (res_valid) valid_seen++;
    end
    chk("rm.no_valid", valid_seen, 0);
    req0 = 1'b1; a0 = 8'h01; b0 = 8'h01;
    req1 = 1'b1; a1 = 8'h77; b1 = 8'h11;
    @(negedge clk);
    chk("rm.first_gnt", {ack0, ack1}, 2'b10);
    req0 = 1'b0;
    req1 = 1'b0;
    n = 0;
    while (!res_valid && n < 20) begin @(negedge clk); n++; end
    chk("rm.sum", sum, 8'h02);
    chk("rm.res_id", res_id, 1'b0);
    @(negedge clk);

`ifdef SERIAL_SUB_EN
    sub0 = 1'b1;
    op("sub_10_20", 1'b0, 8'h10, 8'h20, 8'hF0, 1'b0);
    chk("sub_10_20.res_sub", res_sub, 1'b1);
    op("sub_20_10", 1'b0, 8'h20, 8'h10, 8'h10, 1'b1);
    sub0 = 1'b0;
    op("sub_off", 1'b0, 8'h20, 8'h10, 8'h30, 1'b0);
    chk("sub_off.res_sub", res_sub, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/serial_add_scheduler.md
Name: serial_add_scheduler

Overview:
- Shares one bit-serial adder datapath between two requesters.
- Round-robin arbitration between the two request ports.
- Sequences the operand load, WIDTH serial add cycles and result capture, then holds the result until the consumer takes it with a valid/ready handshake.
- Sits between the operand-producing logic and the result consumer in the serial arithmetic unit.

Parameters:
WIDTH, 8, operand and sum width in bits; legal range 2..32.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-low reset (0 = reset)
req0  input  1  requester 0 request; held high with a0/b0 stable until ack0
a0  input  WIDTH  requester 0 operand A
b0  input  WIDTH  requester 0 operand B
ack0  output  1  one-cycle pulse: requester 0 operands captured
req1  input  1  requester 1 request; same rules as req0
a1  input  WIDTH  requester 1 operand A
b1  input  WIDTH  requester 1 operand B
ack1  output  1  one-cycle pulse: requester 1 operands captured
busy  output  1  high in SHIFT and DONE
res_valid  output  1  result available
res_ready  input  1  consumer accepts result
res_id  output  1  requester that owns the result
sum  output  WIDTH  A+B mod 2^WIDTH
cout  output  1  carry out of the MSB

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; ack0, ack1, busy, res_valid, res_id, sum, cout all 0.
  - Operand shift registers, carry FF and bit counter cleared; round-robin pointer last_gnt=1, so requester 0 wins first.
- States:
  - IDLE: accepts requests.
  - SHIFT: serial add.
  - DONE: holds the result.
- IDLE, on an edge with req0|req1:
  - Grant by round-robin: if both are requesting, grant the one not equal to last_gnt; otherwise grant the lone requester. Update last_gnt.
  - Latch the granted a/b into the shift registers; carry=0; cnt=0; res_id=granted id; state goes to SHIFT.
  - The matching ackN is high for exactly the following cycle.
- SHIFT, each edge:
  - s = A[0]^B[0]^carry; carry = majority(A[0],B[0],carry).
  - A and B shift right with zero fill; s shifts into the sum register MSB (sum right-shifts).
  - cnt increments.
  - On the WIDTH-th SHIFT edge, the last bit is consumed, cout=final carry, and state goes to DONE.
- DONE:
  - res_valid=1; sum, cout and res_id stay stable.
  - On an edge with res_ready=1: res_valid goes to 0 and state goes to IDLE.
  - New requests are not accepted in the same edge.
- Latency: grant edge to res_valid high is exactly WIDTH edges. With res_ready held high, back-to-back operations start every WIDTH+2 cycles.
- Request rules:
  - Requests in SHIFT or DONE are ignored and wait; no ack is issued.
  - res_ready while res_valid=0 is ignored.
  - sum/cout keep their last value after the handshake until the next DONE; the value in SHIFT is don't-care.
- A requester dropping req before ack is legal and is simply not served.
- Reset asserted mid-SHIFT or in DONE aborts the operation: no result, no ack, last_gnt back to 1.
- No combinational path from any input to any output; all outputs are registered.

Optional Feature:
- Macro: SERIAL_SUB_EN
- Defined:
  - Adds ports sub0 and sub1 (input, 1), sampled with the request.
  - If the granted requester's sub=1: B is latched inverted and carry is initialised to 1, so sum=A-B mod 2^WIDTH.
  - cout=1 means no borrow (A>=B).
  - Adds output res_sub (1), which reflects the captured mode; its reset value is 0.
- Undefined: ports absent; addition only.

Test Plan (WIDTH=8):
- Single add: req0, a0=0x5A, b0=0x3C, res_ready=1 -> ack0 one cycle after grant; res_valid 8 edges after grant; sum=0x96, cout=0, res_id=0.
- Carry and wrap: req1, a1=0xFF, b1=0x01 -> sum=0x00, cout=1, res_id=1. Then a1=0x80, b1=0x80 -> sum=0x00, cout=1.
- Arbitration: req0 and req1 held together from reset, res_ready=1 -> grant order 0,1,0,1; each ack is a single pulse; each operation's start is WIDTH+2 cycles after the previous one.
- Backpressure: complete 0x12+0x34, hold res_ready=0 for 5 cycles -> res_valid, sum=0x46 and res_id stay stable; req0 is not acked until after the handshake.
- Reset mid-operation: rst=0 on the 4th SHIFT cycle -> all outputs 0 immediately, no res_valid. Next req0 0x01+0x01 -> sum=0x02, requester 0 is granted first.
- SERIAL_SUB_EN: req0, sub0=1, a0=0x10, b0=0x20 -> sum=0xF0, cout=0, res_sub=1. With a0=0x20, b0=0x10 -> sum=0x10, cout=1.
